// File: rtl/elastic_context_fork_pkg.sv
// Shared types and the context wrap rule for the elastic context stages.
// The fork, mux and ALU stages all advance their context index with next_context.
package elastic_context_fork_pkg;

  localparam int unsigned DefaultContextSize = 16;
  localparam int unsigned DefaultNumOutputs  = 4;
  localparam int unsigned DefaultContextBits = $clog2(DefaultContextSize);

  typedef logic [DefaultContextBits-1:0] ContextIndex;

  typedef struct packed {
    logic [DefaultNumOutputs-1:0] output_mask;
  } ElasticForkConfig;

  // Wrap to 0 at the effective maximum, which is clamped to the memory depth.
  // Any index already beyond that maximum also returns to 0.
  function automatic int unsigned next_context(int unsigned idx, int unsigned max_id,
                                               int unsigned size);
    int unsigned max_eff;
    max_eff = (max_id > size - 1) ? size - 1 : max_id;
    return (idx >= max_eff) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/elastic_context_fork_if.sv
// Elastic valid/stop token bundle between a producer and NUM_OUTPUTS consumers.
interface elastic_context_fork_if #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_OUTPUTS = 4
);

  logic [DATA_WIDTH-1:0]                  input_data;
  logic                                   valid_input;
  logic                                   stop_input;
  logic [NUM_OUTPUTS-1:0][DATA_WIDTH-1:0] output_data;
  logic [NUM_OUTPUTS-1:0]                 valid_output;
  logic [NUM_OUTPUTS-1:0]                 stop_output;

  modport master (
    output input_data,
    output valid_input,
    output stop_output,
    input  stop_input,
    input  output_data,
    input  valid_output
  );

  modport slave (
    input  input_data,
    input  valid_input,
    input  stop_output,
    output stop_input,
    output output_data,
    output valid_output
  );

endinterface

// File: rtl/elastic_context_counter.sv
// Context index register: start_exec forces 0, otherwise advance wraps at the
// clamped maximum context.
module elastic_context_counter
  import elastic_context_fork_pkg::*;
#(
  parameter int unsigned CONTEXT_SIZE            = 16,
  parameter int unsigned CONTEXT_SIZE_BIT_LENGTH = $clog2(CONTEXT_SIZE)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               advance,
  input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] max_id,
  output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] index
);

  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] index_q, index_d;

  always_comb begin
    index_d = index_q;
    if (start) begin
      index_d = '0;
    end else if (advance) begin
      index_d = CONTEXT_SIZE_BIT_LENGTH'(next_context(32'(index_q), 32'(max_id),
                                                      CONTEXT_SIZE));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index_q <= '0;
    end else begin
      index_q <= index_d;
    end
  end

  assign index = index_q;

endmodule

// File: rtl/elastic_context_fork.sv
// Broadcasts one elastic token to the consumers selected by the per-context mask,
// in eager (per-output done bits) or lazy (all-or-nothing) fork mode.
module elastic_context_fork
  import elastic_context_fork_pkg::*;
#(
  parameter int unsigned DATA_WIDTH              = 32,
  parameter int unsigned NUM_OUTPUTS             = 4,
  parameter int unsigned CONTEXT_SIZE            = 16,
  parameter int unsigned CONTEXT_SIZE_BIT_LENGTH = $clog2(CONTEXT_SIZE),
  parameter int unsigned EAGER_MODE              = 1,
  parameter int unsigned DROP_COUNT_WIDTH        = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               write_config_data,
  input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] config_index,
  input  logic [NUM_OUTPUTS-1:0]             config_output_mask,
  input  logic                               start_exec,
  input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] mapping_context_max_id,
  elastic_context_fork_if.slave              tok,
  output logic                               switch_context,
  output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] context_id,
  output logic [DROP_COUNT_WIDTH-1:0]        drop_count
);

  logic [NUM_OUTPUTS-1:0]      cfg_q [CONTEXT_SIZE];
  logic [NUM_OUTPUTS-1:0]      mask;
  logic [NUM_OUTPUTS-1:0]      valid_out;
  logic                        complete;
  logic                        running_q;
  logic [DROP_COUNT_WIDTH-1:0] drop_q;
  logic [DATA_WIDTH-1:0]       token_data;

  // Writes beyond the memory depth are discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CONTEXT_SIZE; i++) cfg_q[i] <= '0;
    end else if (write_config_data && (32'(config_index) < CONTEXT_SIZE)) begin
      cfg_q[config_index] <= config_output_mask;
    end
  end

  assign mask = cfg_q[context_id];

  if (EAGER_MODE != 0) begin : g_eager
    logic [NUM_OUTPUTS-1:0] done_q, done_d, xfer;

    always_comb begin
      valid_out = {NUM_OUTPUTS{running_q & tok.valid_input}} & mask & ~done_q;
      xfer      = valid_out & ~tok.stop_output;
      complete  = running_q & tok.valid_input & (&(~mask | done_q | xfer));
      done_d    = done_q | xfer;
      if (start_exec || complete) done_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        done_q <= '0;
      end else begin
        done_q <= done_d;
      end
    end
  end else begin : g_lazy
    logic all_ready;

    assign all_ready = &(~mask | ~tok.stop_output);
    assign valid_out = {NUM_OUTPUTS{running_q & tok.valid_input & all_ready}} & mask;
    assign complete  = running_q & tok.valid_input & all_ready;
  end

  // A start_exec in the same cycle abandons the token, so it is not counted as dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      running_q <= 1'b0;
      drop_q    <= '0;
    end else begin
      if (start_exec) running_q <= 1'b1;
      if (complete && !start_exec && (mask == '0) && (drop_q != '1)) begin
        drop_q <= drop_q + DROP_COUNT_WIDTH'(1);
      end
    end
  end

  elastic_context_counter #(
    .CONTEXT_SIZE            (CONTEXT_SIZE),
    .CONTEXT_SIZE_BIT_LENGTH (CONTEXT_SIZE_BIT_LENGTH)
  ) u_counter (
    .clk     (clk),
    .reset   (reset),
    .start   (start_exec),
    .advance (complete),
    .max_id  (mapping_context_max_id),
    .index   (context_id)
  );

  assign token_data       = tok.input_data;
  assign tok.output_data  = {NUM_OUTPUTS{token_data}};
  assign tok.valid_output = valid_out;
  assign tok.stop_input   = ~running_q | (tok.valid_input & ~complete);
  assign switch_context   = complete;
  assign drop_count       = drop_q;

endmodule

// File: tb/tb_elastic_context_fork.sv
// Self-checking bench: eager, lazy and a 12-deep eager fork driven in parallel
// and compared every cycle against a behavioural token model.
module tb_elastic_context_fork;
  import elastic_context_fork_pkg::*;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             wr = 1'b0;
  ContextIndex      cidx = '0;
  ElasticForkConfig cmask_cfg = '0;
  logic             start = 1'b0;
  ContextIndex      maxid = '0;
  logic             vin = 1'b0;
  logic [31:0]      din = '0;
  logic [3:0]       sout = '0;

  logic [2:0]        sw_o;
  logic [2:0][3:0]   ctx_o;
  logic [2:0][15:0]  drop_o;

  int checks = 0;
  int errors = 0;

  // Model state: index 0 eager/16, 1 lazy/16, 2 eager/12.
  bit [3:0]    m_cfg [16];
  int unsigned m_ctx [3];
  bit [3:0]    m_done [3];
  int unsigned m_drop [3];
  bit          m_running;
  int unsigned m_size [3] = '{16, 16, 12};

  always #5 clk = ~clk;

  elastic_context_fork_if #(.DATA_WIDTH(32), .NUM_OUTPUTS(4)) tok_e ();
  elastic_context_fork_if #(.DATA_WIDTH(32), .NUM_OUTPUTS(4)) tok_l ();
  elastic_context_fork_if #(.DATA_WIDTH(32), .NUM_OUTPUTS(4)) tok_c ();

  assign tok_e.input_data = din;
  assign tok_e.valid_input = vin;
  assign tok_e.stop_output = sout;
  assign tok_l.input_data = din;
  assign tok_l.valid_input = vin;
  assign tok_l.stop_output = sout;
  assign tok_c.input_data = din;
  assign tok_c.valid_input = vin;
  assign tok_c.stop_output = sout;

  elastic_context_fork #(
    .DATA_WIDTH(32), .NUM_OUTPUTS(4), .CONTEXT_SIZE(16), .EAGER_MODE(1), .DROP_COUNT_WIDTH(16)
  ) dut_e (
    .clk(clk), .reset(reset), .write_config_data(wr), .config_index(cidx),
    .config_output_mask(cmask_cfg.output_mask), .start_exec(start),
    .mapping_context_max_id(maxid), .tok(tok_e), .switch_context(sw_o[0]),
    .context_id(ctx_o[0]), .drop_count(drop_o[0])
  );

  elastic_context_fork #(
    .DATA_WIDTH(32), .NUM_OUTPUTS(4), .CONTEXT_SIZE(16), .EAGER_MODE(0), .DROP_COUNT_WIDTH(16)
  ) dut_l (
    .clk(clk), .reset(reset), .write_config_data(wr), .config_index(cidx),
    .config_output_mask(cmask_cfg.output_mask), .start_exec(start),
    .mapping_context_max_id(maxid), .tok(tok_l), .switch_context(sw_o[1]),
    .context_id(ctx_o[1]), .drop_count(drop_o[1])
  );

  elastic_context_fork #(
    .DATA_WIDTH(32), .NUM_OUTPUTS(4), .CONTEXT_SIZE(12), .CONTEXT_SIZE_BIT_LENGTH(4),
    .EAGER_MODE(1), .DROP_COUNT_WIDTH(16)
  ) dut_c (
    .clk(clk), .reset(reset), .write_config_data(wr), .config_index(cidx),
    .config_output_mask(cmask_cfg.output_mask), .start_exec(start),
    .mapping_context_max_id(maxid), .tok(tok_c), .switch_context(sw_o[2]),
    .context_id(ctx_o[2]), .drop_count(drop_o[2])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int unsigned wrap_next(int unsigned ctx, int unsigned lim_in,
                                            int unsigned size);
    int unsigned lim;
    lim = (lim_in > size - 1) ? size - 1 : lim_in;
    return (ctx >= lim) ? 0 : ctx + 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_cfg[i] = '0;
    for (int d = 0; d < 3; d++) begin
      m_ctx[d] = 0;
      m_done[d] = '0;
      m_drop[d] = 0;
    end
    m_running = 1'b0;
  endtask

  // Expected combinational outputs of fork d for the current inputs.
  function automatic void predict(input int d, output logic [3:0] v, output logic stp,
                                  output logic sw);
    logic [3:0] mask;
    int blocked;
    mask = m_cfg[m_ctx[d]];
    v = '0;
    sw = 1'b0;
    blocked = 0;
    if (m_running && vin) begin
      for (int i = 0; i < 4; i++) begin
        if (mask[i] && (d == 1 || !m_done[d][i]) && sout[i]) blocked++;
      end
      if (d == 1) begin
        if (blocked == 0) begin
          v = mask;
          sw = 1'b1;
        end
      end else begin
        for (int i = 0; i < 4; i++) v[i] = mask[i] && !m_done[d][i];
        sw = (blocked == 0);
      end
    end
    stp = !m_running || (vin && !sw);
  endfunction

  task automatic model_update();
    logic [3:0] v [3];
    logic       s [3];
    logic       c [3];
    logic [3:0] msk [3];
    if (reset) begin
      model_reset();
      return;
    end
    for (int d = 0; d < 3; d++) begin
      predict(d, v[d], s[d], c[d]);
      msk[d] = m_cfg[m_ctx[d]];
    end
    if (wr) m_cfg[cidx] = cmask_cfg.output_mask;
    for (int d = 0; d < 3; d++) begin
      if (start) begin
        m_ctx[d] = 0;
        m_done[d] = '0;
      end else if (c[d]) begin
        if (msk[d] == 0 && m_drop[d] < 65535) m_drop[d]++;
        m_ctx[d] = wrap_next(m_ctx[d], maxid, m_size[d]);
        m_done[d] = '0;
      end else if (d != 1) begin
        for (int i = 0; i < 4; i++) if (v[d][i] && !sout[i]) m_done[d][i] = 1'b1;
      end
    end
    if (start) m_running = 1'b1;
  endtask

  task automatic check_model();
    logic [3:0]   ev, av;
    logic         es, esw, as_;
    logic [127:0] od;
    for (int d = 0; d < 3; d++) begin
      predict(d, ev, es, esw);
      case (d)
        0: begin av = tok_e.valid_output; as_ = tok_e.stop_input; od = tok_e.output_data; end
        1: begin av = tok_l.valid_output; as_ = tok_l.stop_input; od = tok_l.output_data; end
        default: begin
          av = tok_c.valid_output; as_ = tok_c.stop_input; od = tok_c.output_data;
        end
      endcase
      chk($sformatf("valid_output dut%0d", d), 32'(av), 32'(ev));
      chk($sformatf("stop_input dut%0d", d), 32'(as_), 32'(es));
      chk($sformatf("switch_context dut%0d", d), 32'(sw_o[d]), 32'(esw));
      chk($sformatf("context_id dut%0d", d), 32'(ctx_o[d]), m_ctx[d]);
      chk($sformatf("drop_count dut%0d", d), 32'(drop_o[d]), m_drop[d]);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("output_data[%0d] dut%0d", i, d), od[i*32 +: 32], din);
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    check_model();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cycle();
    settle();
    advance();
  endtask

  task automatic write_cfg(input int idx, input logic [3:0] m);
    wr = 1'b1;
    cidx = ContextIndex'(idx);
    cmask_cfg.output_mask = m;
    cycle();
    wr = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic pulse_reset();
    vin = 1'b0;
    reset = 1'b1;
    model_reset();
    cycle();
    reset = 1'b0;
  endtask

  typedef struct packed {
    logic       vin;
    logic [3:0] sout;
    logic [3:0] ev;
    logic       es;
    logic       esw;
    logic [3:0] lv;
    logic       ls;
    logic       lsw;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        vecs [5];
    int unsigned seq3 [4];
    model_reset();

    // Reset state.
    repeat (2) begin
      settle();
      chk("reset valid_output", 32'(tok_e.valid_output), 32'd0);
      chk("reset stop_input", 32'(tok_e.stop_input), 32'd1);
      chk("reset switch_context", 32'(sw_o[0]), 32'd0);
      advance();
    end
    reset = 1'b0;
    cycle();

    // Eager vs lazy under a stalled output 1.
    vecs[0] = '{1'b1, 4'b0010, 4'b1011, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 4'b0010, 4'b0010, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 4'b0010, 4'b0010, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 4'b0000, 4'b0010, 1'b0, 1'b1, 4'b1011, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
    write_cfg(0, 4'b1011);
    maxid = 4'd0;
    do_start();
    din = 32'hA5;
    for (int k = 0; k < 5; k++) begin
      vin = vecs[k].vin;
      sout = vecs[k].sout;
      settle();
      chk($sformatf("vec%0d eager valid", k), 32'(tok_e.valid_output), 32'(vecs[k].ev));
      chk($sformatf("vec%0d eager stop", k), 32'(tok_e.stop_input), 32'(vecs[k].es));
      chk($sformatf("vec%0d eager switch", k), 32'(sw_o[0]), 32'(vecs[k].esw));
      chk($sformatf("vec%0d lazy valid", k), 32'(tok_l.valid_output), 32'(vecs[k].lv));
      chk($sformatf("vec%0d lazy stop", k), 32'(tok_l.stop_input), 32'(vecs[k].ls));
      chk($sformatf("vec%0d lazy switch", k), 32'(sw_o[1]), 32'(vecs[k].lsw));
      advance();
    end

    // Context sequence with a zero-mask drop.
    pulse_reset();
    write_cfg(0, 4'b0001);
    write_cfg(1, 4'b0000);
    write_cfg(2, 4'b0100);
    maxid = 4'd2;
    do_start();
    seq3 = '{0, 1, 2, 0};
    sout = '0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("seq ctx step%0d", k), 32'(ctx_o[0]), seq3[k]);
      vin = 1'b1;
      din = $urandom;
      cycle();
    end
    vin = 1'b0;
    chk("drop after wrap eager", 32'(drop_o[0]), 32'd1);
    chk("drop after wrap lazy", 32'(drop_o[1]), 32'd1);

    // Full wrap, clamped wrap on the 12-deep fork, then max lowered below the index.
    pulse_reset();
    for (int i = 0; i < 16; i++) write_cfg(i, 4'b0001);
    maxid = 4'd15;
    do_start();
    vin = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k == 12) chk("clamped wrap 11->0", 32'(ctx_o[2]), 32'd0);
      if (k == 15) chk("ctx reaches 15", 32'(ctx_o[0]), 32'd15);
      cycle();
    end
    chk("wrap 15->0", 32'(ctx_o[0]), 32'd0);
    repeat (7) cycle();
    chk("ctx at 7", 32'(ctx_o[0]), 32'd7);
    vin = 1'b0;
    maxid = 4'd3;
    cycle();
    vin = 1'b1;
    cycle();
    chk("lowered max ctx", 32'(ctx_o[0]), 32'd0);
    chk("lowered max ctx clamped", 32'(ctx_o[2]), 32'd0);
    vin = 1'b0;

    // start_exec wins over a same-cycle completion.
    pulse_reset();
    for (int i = 0; i < 5; i++) write_cfg(i, 4'b0001);
    maxid = 4'd10;
    do_start();
    vin = 1'b1;
    repeat (3) cycle();
    chk("ctx before restart", 32'(ctx_o[0]), 32'd3);
    start = 1'b1;
    settle();
    chk("complete with start", 32'(sw_o[0]), 32'd1);
    advance();
    start = 1'b0;
    chk("restart ctx eager", 32'(ctx_o[0]), 32'd0);
    chk("restart ctx lazy", 32'(ctx_o[1]), 32'd0);
    vin = 1'b0;

    // Reset mid-token with a done bit set, then masks read back as zero.
    pulse_reset();
    write_cfg(0, 4'b0011);
    maxid = 4'd0;
    do_start();
    vin = 1'b1;
    sout = 4'b0010;
    cycle();
    reset = 1'b1;
    model_reset();
    #1;
    chk("mid reset valid", 32'(tok_e.valid_output), 32'd0);
    chk("mid reset stop", 32'(tok_e.stop_input), 32'd1);
    cycle();
    reset = 1'b0;
    chk("post reset ctx", 32'(ctx_o[0]), 32'd0);
    chk("post reset drop", 32'(drop_o[0]), 32'd0);
    sout = '0;
    maxid = 4'd15;
    do_start();
    repeat (4) cycle();
    chk("cleared masks drop", 32'(drop_o[0]), 32'd4);
    vin = 1'b0;

    // Randomised traffic against the model.
    for (int k = 0; k < 400; k++) begin
      wr = ($urandom_range(9) == 0);
      cidx = ContextIndex'($urandom_range(15));
      cmask_cfg.output_mask = 4'($urandom);
      start = ($urandom_range(39) == 0);
      if ($urandom_range(19) == 0) maxid = ContextIndex'($urandom_range(15));
      vin = ($urandom_range(4) != 0);
      din = $urandom;
      sout = 4'($urandom & $urandom);
      cycle();
    end
    wr = 1'b0;
    start = 1'b0;
    vin = 1'b0;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
